icache: RTL and testbench

Direct-mapped, read-only instruction cache between the rv32i fetch stage and the multi-cycle instruction ROM. Fetch reads arrive on a request/valid handshake. Hits return in one cycle. A miss issues a single line request to the ROM, waits for its 4-word burst, fills the line, then answers fetch.

---
 rtl/icache_pkg.sv | 11 +
 rtl/icache_line_ram.sv | 50 +++++
 rtl/icache.sv | 112 +++++++++++
 tb/tb_icache.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared cache geometry and FSM state type for the rv32i instruction cache.
package rv32i;
    localparam int CACHE_WORD_ADR_SIZE = 2;
    localparam int CACHE_WORDS         = 1 << CACHE_WORD_ADR_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } icache_state_t;
endpackage

// File: rtl/icache_line_ram.sv
// Tag/valid/data storage for the icache: asynchronous read, whole-line synchronous write.
module icache_line_ram
    import rv32i::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_all,
    input  logic                         we,
    input  logic [INDEX_BITS-1:0]        widx,
    input  logic [TAG_BITS-1:0]          wtag,
    input  logic                         wvalid,
    input  logic [CACHE_WORDS-1:0][31:0] wdata,
    input  logic [INDEX_BITS-1:0]        ridx,
    output logic [TAG_BITS-1:0]          rtag,
    output logic                         rvalid,
    output logic [CACHE_WORDS-1:0][31:0] rdata
);
    localparam int LINES = 1 << INDEX_BITS;

    (* ramstyle = "MLAB" *) logic [TAG_BITS-1:0]          tag_mem  [LINES];
    (* ramstyle = "MLAB" *) logic [CACHE_WORDS-1:0][31:0] data_mem [LINES];
    logic [LINES-1:0] valid;

    // A fill coinciding with clear_all still writes its own valid bit; the
    // caller drives wvalid=0 in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (clear_all)
                valid <= '0;
            if (we)
                valid[widx] <= wvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rtag   = tag_mem[ridx];
    assign rvalid = valid[ridx];
    assign rdata  = data_mem[ridx];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, single outstanding line fill on miss.
module icache
    import rv32i::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 32 - INDEX_BITS - CACHE_WORD_ADR_SIZE - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  cpu_addr,
    input  logic                         cpu_re,
    input  logic                         flush,
    output logic [31:0]                  cpu_data,
    output logic                         cpu_valid,
    output logic [31:0]                  mem_addr,
    output logic                         mem_re,
    input  logic [CACHE_WORDS-1:0][31:0] mem_data,
    input  logic                         mem_oe
);
    localparam int IDX_LO = CACHE_WORD_ADR_SIZE + 2;
    localparam int TAG_LO = IDX_LO + INDEX_BITS;
    localparam int LINE_W = 32 - IDX_LO;

    icache_state_t state;

    logic [INDEX_BITS-1:0]          rd_idx;
    logic [TAG_BITS-1:0]            rd_tag;
    logic [CACHE_WORD_ADR_SIZE-1:0] rd_off;
    logic [TAG_BITS-1:0]            ram_tag;
    logic                           ram_valid;
    logic [CACHE_WORDS-1:0][31:0]   ram_data;
    logic                           hit;
    logic                           fill;
    logic                           addr_unused;

    logic [LINE_W-1:0]              miss_line;
    logic [CACHE_WORD_ADR_SIZE-1:0] miss_off;
    logic                           miss_flushed;

    assign rd_idx      = cpu_addr[TAG_LO-1:IDX_LO];
    assign rd_tag      = cpu_addr[31:TAG_LO];
    assign rd_off      = cpu_addr[IDX_LO-1:2];
    assign addr_unused = ^cpu_addr[1:0];

    assign hit    = ram_valid && (ram_tag == rd_tag);
    assign fill   = (state == WAIT) && mem_oe;
    assign mem_re = (state == REQ);

    icache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .clear_all (flush),
        .we        (fill),
        .widx      (miss_line[INDEX_BITS-1:0]),
        .wtag      (miss_line[LINE_W-1:INDEX_BITS]),
        .wvalid    (!(miss_flushed || flush)),
        .wdata     (mem_data),
        .ridx      (rd_idx),
        .rtag      (ram_tag),
        .rvalid    (ram_valid),
        .rdata     (ram_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cpu_valid    <= 1'b0;
            cpu_data     <= '0;
            mem_addr     <= '0;
            miss_line    <= '0;
            miss_off     <= '0;
            miss_flushed <= 1'b0;
        end else begin
            cpu_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_re) begin
                        // A flush on the request edge invalidates the line being looked up.
                        if (hit && !flush) begin
                            cpu_valid <= 1'b1;
                            cpu_data  <= ram_data[rd_off];
                        end else begin
                            miss_line    <= cpu_addr[31:IDX_LO];
                            miss_off     <= rd_off;
                            miss_flushed <= 1'b0;
                            mem_addr     <= {cpu_addr[31:IDX_LO], {IDX_LO{1'b0}}};
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush)
                        miss_flushed <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (flush)
                        miss_flushed <= 1'b1;
                    if (mem_oe) begin
                        cpu_valid <= 1'b1;
                        cpu_data  <= mem_data[miss_off];
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: transaction-level cache model predicts per-cycle responses and ROM requests.
module tb_icache;
    localparam int DELAY = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      cpu_addr;
    logic             cpu_re;
    logic             flush;
    logic [31:0]      cpu_data;
    logic             cpu_valid;
    logic [31:0]      mem_addr;
    logic             mem_re;
    logic [3:0][31:0] mem_data;
    logic             mem_oe;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_re    (cpu_re),
        .flush     (flush),
        .cpu_data  (cpu_data),
        .cpu_valid (cpu_valid),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_data  (mem_data),
        .mem_oe    (mem_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    typedef struct {
        int          at;
        logic [31:0] val;
    } ev_t;
    ev_t qv[$];
    ev_t qm[$];

    // Model of cache residency: which tag each line holds, if any
    bit          mv [64];
    logic [21:0] mt [64];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA000_0000 + {a[31:2], 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    // ROM: answers each mem_re with a line-ready pulse DELAY+1 cycles later
    initial begin
        int          oe_at;
        logic [31:0] base;
        oe_at    = -1;
        base     = '0;
        mem_oe   = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_re) begin
                oe_at = cyc + DELAY + 1;
                base  = mem_addr;
            end
            mem_oe = (cyc == oe_at);
            if (mem_oe)
                for (int i = 0; i < 4; i++) mem_data[i] = rom_word(base + 32'(4 * i));
        end
    end

    // Per-cycle compare against the predicted event queues
    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                bit ev, em;
                ev = (qv.size() > 0) && (qv[0].at == cyc);
                em = (qm.size() > 0) && (qm[0].at == cyc);
                chk("cpu_valid", {31'b0, cpu_valid}, {31'b0, ev});
                if (ev) begin
                    if (cpu_valid) chk("cpu_data", cpu_data, qv[0].val);
                    void'(qv.pop_front());
                end
                chk("mem_re", {31'b0, mem_re}, {31'b0, em});
                if (em) begin
                    if (mem_re) chk("mem_addr", mem_addr, qm[0].val);
                    void'(qm.pop_front());
                end
            end
        end
    end

    // Issue one fetch and hold it until its response cycle (leaves cpu_re high on return).
    task automatic fetch(input logic [31:0] a, input bit fl_req, input bit fl_wait, input bit rst_wait);
        int          n;
        bit          hit;
        logic [5:0]  idx;
        logic [21:0] tg;
        idx = a[9:4];
        tg  = a[31:10];
        hit = !fl_req && mv[idx] && (mt[idx] == tg);
        if (fl_req) clear_model();
        n        = cyc;
        cpu_addr = a;
        cpu_re   = 1'b1;
        flush    = fl_req;
        if (hit) begin
            qv.push_back('{n + 1, rom_word(a)});
            step();
            flush = 1'b0;
        end else begin
            qm.push_back('{n + 1, {a[31:4], 4'b0}});
            if (!rst_wait) qv.push_back('{n + DELAY + 3, rom_word(a)});
            step();
            flush = 1'b0;
            step();
            step();
            if (fl_wait) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                clear_model();
            end
            if (rst_wait) begin
                rst    = 1'b1;
                cpu_re = 1'b0;
                step();
                rst = 1'b0;
                clear_model();
                while (cyc < n + DELAY + 4) step();
                return;
            end
            while (cyc < n + DELAY + 3) step();
            mv[idx] = !fl_wait;
            mt[idx] = tg;
        end
    endtask

    task automatic idle(input int k);
        cpu_re = 1'b0;
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        clear_model();
        rst      = 1'b1;
        cpu_addr = '0;
        cpu_re   = 1'b0;
        flush    = 1'b0;
        step();
        step();
        chk("rst_cpu_valid", {31'b0, cpu_valid}, 32'd0);
        chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        run = 1'b1;
        idle(2);

        // Cold miss, then three back-to-back hits on the same line
        fetch(32'h0000_0008, 0, 0, 0);
        chk("cold_valid", {31'b0, cpu_valid}, 32'd1);
        chk("cold_data", cpu_data, 32'hA000_0008);
        fetch(32'h0000_0000, 0, 0, 0);
        chk("hit0_data", cpu_data, 32'hA000_0000);
        fetch(32'h0000_0004, 0, 0, 0);
        chk("hit1_data", cpu_data, 32'hA000_0004);
        fetch(32'h0000_000C, 0, 0, 0);
        chk("hit3_data", cpu_data, 32'hA000_000C);
        idle(2);

        // Stand-alone flush, then conflict eviction on index 0
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_model();
        idle(1);
        fetch(32'h0000_0000, 0, 0, 0);
        fetch(32'h0000_0400, 0, 0, 0);
        chk("evict_data", cpu_data, 32'hA000_0400);
        fetch(32'h0000_0000, 0, 0, 0);
        idle(2);

        // Flush during a fill, re-read, flush with request, then a hit
        fetch(32'h0000_0010, 0, 1, 0);
        chk("flushfill_data", cpu_data, 32'hA000_0010);
        idle(1);
        fetch(32'h0000_0010, 0, 0, 0);
        fetch(32'h0000_0010, 1, 0, 0);
        fetch(32'h0000_0014, 0, 0, 0);
        chk("after_flushreq_hit", cpu_data, 32'hA000_0014);
        idle(2);

        // Reset mid-miss: late line-ready is ignored, the next read misses again
        fetch(32'h0000_0020, 0, 0, 1);
        idle(1);
        fetch(32'h0000_0020, 0, 0, 0);
        chk("post_rst_data", cpu_data, 32'hA000_0020);
        idle(3);

        run = 1'b0;
        if (qv.size() != 0 || qm.size() != 0) begin
            bad++;
            total++;
            $display("FAIL pending_events: got %0d/%0d left, want 0/0", qv.size(), qm.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end
endmodule
